// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache fill path.
//   fill_state_t : fill FSM states
//   line_t       : one 128-byte cache line, element k = line byte k
//   tag_t        : per-line tag (pc[31:9])
package icache_pkg;

    localparam int NUM_LINES      = 4;
    localparam int LINE_BYTES     = 128;
    localparam int BEAT_BYTES     = 16;
    localparam int TAG_W          = 23;
    localparam int BEATS_PER_LINE = LINE_BYTES / BEAT_BYTES;
    localparam int IDX_W          = $clog2(NUM_LINES);
    localparam int BEAT_W         = $clog2(BEATS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fill_state_t;

    typedef logic [LINE_BYTES-1:0][7:0] line_t;
    typedef logic [TAG_W-1:0]           tag_t;

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: NUM_LINES lines of LINE_BYTES bytes each.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (clears all bytes)
//   we              : write one beat this edge
//   idx             : line being written
//   beat            : beat number within the line
//   wdata           : beat data, byte i lands at line byte BEAT_BYTES*beat + i
//   block0..block3  : full contents of each line, read combinationally by fetch
module icache_line_store
    import icache_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [IDX_W-1:0]               idx,
    input  logic [BEAT_W-1:0]              beat,
    input  logic [BEAT_BYTES*8-1:0]        wdata,
    output line_t                          block0,
    output line_t                          block1,
    output line_t                          block2,
    output line_t                          block3
);

    line_t lines [NUM_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < NUM_LINES; l++) begin
                lines[l] <= '0;
            end
        end else if (we) begin
            // Byte address within the line is {beat, byte-in-beat}.
            for (int i = 0; i < BEAT_BYTES; i++) begin
                lines[idx][{beat, 4'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

    assign block0 = lines[0];
    assign block1 = lines[1];
    assign block2 = lines[2];
    assign block3 = lines[3];

endmodule

// File: rtl/icache_fill.sv
// Instruction-cache miss service: fetches one line as BEATS_PER_LINE beats,
// writes it into the direct-mapped line selected by miss_pc[8:7], then sets
// that line's tag/valid and pulses cache_load so fetch retries.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   miss_req, miss_pc     : fetch miss request (sampled only in IDLE)
//   inv_all               : clear all valid bits on the next edge
//   mem_req, mem_addr     : line read request, held until mem_ready
//   mem_ready             : memory accepts the request
//   mem_rvalid, mem_rdata : read data beats
//   cache_block0..3       : line storage
//   cache_tag, cache_v    : per-line tag and valid
//   cache_load            : one-cycle fill-complete pulse
//   busy                  : FSM not in IDLE
module icache_fill
    import icache_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_req,
    input  logic [31:0]                       miss_pc,
    input  logic                              inv_all,
    output logic                              mem_req,
    output logic [31:0]                       mem_addr,
    input  logic                              mem_ready,
    input  logic                              mem_rvalid,
    input  logic [BEAT_BYTES*8-1:0]           mem_rdata,
    output line_t                             cache_block0,
    output line_t                             cache_block1,
    output line_t                             cache_block2,
    output line_t                             cache_block3,
    output logic [NUM_LINES-1:0][TAG_W-1:0]   cache_tag,
    output logic [NUM_LINES-1:0]              cache_v,
    output logic                              cache_load,
    output logic                              busy
);

    fill_state_t        state;
    logic [IDX_W-1:0]   idx_q;
    tag_t               tag_q;
    logic [BEAT_W-1:0]  cnt;
    logic               store_we;
    logic               unused_pc_off;

    // The line offset bits never matter: requests are line-aligned.
    assign unused_pc_off = ^miss_pc[6:0];

    assign store_we = (state == DATA) && mem_rvalid;

    icache_line_store u_store (
        .clk    (clk),
        .rst    (rst),
        .we     (store_we),
        .idx    (idx_q),
        .beat   (cnt),
        .wdata  (mem_rdata),
        .block0 (cache_block0),
        .block1 (cache_block1),
        .block2 (cache_block2),
        .block3 (cache_block3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx_q      <= '0;
            tag_q      <= '0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            cache_load <= 1'b0;
            busy       <= 1'b0;
            cache_v    <= '0;
            cache_tag  <= '0;
        end else begin
            cache_load <= 1'b0;
            // Global invalidate first; a fill's own valid set below wins
            // for its line because it is the later assignment.
            if (inv_all) begin
                cache_v <= '0;
            end
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        idx_q                <= miss_pc[8:7];
                        tag_q                <= miss_pc[31:9];
                        mem_addr             <= {miss_pc[31:7], 7'b0};
                        mem_req              <= 1'b1;
                        busy                 <= 1'b1;
                        // Line is stale from the moment its refill starts.
                        cache_v[miss_pc[8:7]] <= 1'b0;
                        state                <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (mem_rvalid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == BEAT_W'(BEATS_PER_LINE - 1)) begin
                            cache_tag[idx_q] <= tag_q;
                            cache_v[idx_q]   <= 1'b1;
                            cache_load       <= 1'b1;
                            state            <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill.sv
module tb_icache_fill;
    import icache_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            miss_req;
    logic [31:0]                     miss_pc;
    logic                            inv_all;
    logic                            mem_req;
    logic [31:0]                     mem_addr;
    logic                            mem_ready;
    logic                            mem_rvalid;
    logic [127:0]                    mem_rdata;
    line_t                           cache_block0, cache_block1, cache_block2, cache_block3;
    logic [NUM_LINES-1:0][TAG_W-1:0] cache_tag;
    logic [NUM_LINES-1:0]            cache_v;
    logic                            cache_load;
    logic                            busy;

    int n_cmp = 0;
    int n_err = 0;

    icache_fill dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_pc      (miss_pc),
        .inv_all      (inv_all),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .cache_block0 (cache_block0),
        .cache_block1 (cache_block1),
        .cache_block2 (cache_block2),
        .cache_block3 (cache_block3),
        .cache_tag    (cache_tag),
        .cache_v      (cache_v),
        .cache_load   (cache_load),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Beat b, byte i carries seed + 16*b + i.
    function automatic logic [127:0] beat_data(input logic [7:0] seed, input int b);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = seed + 8'(16*b + i);
        return d;
    endfunction

    function automatic line_t blk(input logic [1:0] ix);
        case (ix)
            2'd0:    return cache_block0;
            2'd1:    return cache_block1;
            2'd2:    return cache_block2;
            default: return cache_block3;
        endcase
    endfunction

    task automatic check_line(input string tag, input logic [1:0] ix, input logic [7:0] seed);
        line_t l;
        l = blk(ix);
        for (int b = 0; b < 8; b++) chk($sformatf("%s_b%0d", tag, b), l[16*b +: 16], beat_data(seed, b));
    endtask

    // One complete fill, driven at negedges and sampled at negedges.
    task automatic do_fill(input logic [31:0] pc, input logic [7:0] seed, input int rdy_delay,
                           input bit gaps, input int inv_beat, input bit hold_miss, input bit skip_req);
        int edges;
        logic [1:0] ix;
        ix = pc[8:7];
        if (!skip_req) begin
            @(negedge clk);
            miss_req = 1'b1;
            miss_pc  = pc;
            @(posedge clk);
            @(negedge clk);
            if (!hold_miss) miss_req = 1'b0;
        end
        edges = 0;
        chk("req_hi", mem_req, 1);
        chk("req_addr", mem_addr, {pc[31:7], 7'b0});
        chk("v_clr_req", cache_v[ix], 0);
        repeat (rdy_delay) begin
            @(posedge clk); edges++;
            @(negedge clk);
            chk("req_hold", mem_req, 1);
        end
        mem_ready = 1'b1;
        @(posedge clk); edges++;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("req_drop", mem_req, 0);
        for (int b = 0; b < 8; b++) begin
            if (gaps && b > 0) begin
                @(posedge clk); edges++;
                @(negedge clk);
                chk("no_load_gap", cache_load, 0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beat_data(seed, b);
            inv_all    = (b == inv_beat);
            @(posedge clk); edges++;
            @(negedge clk);
            mem_rvalid = 1'b0;
            inv_all    = 1'b0;
            if (b < 7) begin
                chk("no_load_early", cache_load, 0);
                chk("v_low_fill", cache_v[ix], 0);
            end
        end
        chk("load_hi", cache_load, 1);
        // REQ cycle + accept + 8 beats: load visible in the 10th cycle,
        // i.e. after the 9th edge following the request edge.
        if (!gaps && rdy_delay == 0) chk("latency", 128'(edges), 128'(9));
        chk("v_set", cache_v[ix], 1);
        chk("tag_set", cache_tag[ix], pc[31:9]);
        check_line("data", ix, seed);
        if (!hold_miss) begin
            @(posedge clk);
            @(negedge clk);
            chk("load_pulse", cache_load, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        line_t snap;
        bit    saw;
        rst = 1'b1; miss_req = 1'b0; miss_pc = '0; inv_all = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_v", cache_v, 0);
        chk("rst_load", cache_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tag", cache_tag, 0);
        chk("rst_blk3", cache_block3[15:0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic fill: line 3, byte k = k.
        do_fill(32'h0000_0180, 8'h00, 0, 0, -1, 0, 0);
        chk("basic_v", cache_v, 4'b1000);
        chk("basic_tag", cache_tag[3], 0);

        // Spurious rvalid while IDLE must not touch storage.
        snap = cache_block3;
        mem_rvalid = 1'b1; mem_rdata = {128{1'b1}};
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        check_line("spur", 2'd3, 8'h00);
        chk("spur_busy", busy, 0);

        // Stalled memory, line 1.
        do_fill(32'h0000_0080, 8'h40, 3, 1, -1, 0, 0);
        chk("stall_v", cache_v, 4'b1010);

        // Line 0, then invalidate during a line-2 fill.
        do_fill(32'h0000_0000, 8'h20, 0, 0, -1, 0, 0);
        chk("pre_v", cache_v, 4'b1011);
        do_fill(32'h0001_0100, 8'h50, 0, 0, 3, 0, 0);
        chk("inv_v", cache_v, 4'b0100);
        chk("inv_tag2", cache_tag[2], 23'h80);
        check_line("inv_l1_kept", 2'd1, 8'h40);

        // Invalidate on the final beat: own line stays valid.
        do_fill(32'h0000_0000, 8'h60, 0, 0, -1, 0, 0);
        chk("pre2_v", cache_v, 4'b0101);
        do_fill(32'h0000_0080, 8'h70, 0, 0, 7, 0, 0);
        chk("inv_last_v", cache_v, 4'b0010);

        // Refill the same index with a different tag.
        do_fill(32'h0000_0000, 8'h11, 0, 0, -1, 0, 0);
        chk("refill1_tag", cache_tag[0], 0);
        do_fill(32'h0000_0200, 8'h99, 0, 0, -1, 0, 0);
        chk("refill2_tag", cache_tag[0], 1);
        chk("refill_v", cache_v, 4'b0011);
        check_line("other_stable", 2'd1, 8'h70);

        // miss_req held through DONE: next fill only starts from IDLE.
        do_fill(32'h0000_0180, 8'h33, 0, 0, -1, 1, 0);
        chk("done_busy", busy, 1);
        @(posedge clk); @(negedge clk);
        chk("hold_idle_req", mem_req, 0);
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_load", cache_load, 0);
        @(posedge clk); @(negedge clk);
        chk("hold_restart_busy", busy, 1);
        miss_req = 1'b0;
        do_fill(32'h0000_0180, 8'h44, 0, 0, -1, 0, 1);
        chk("hold_v", cache_v, 4'b1011);

        // Asynchronous reset during beat 4 of a line-1 fill.
        @(negedge clk);
        miss_req = 1'b1; miss_pc = 32'h0000_0080;
        @(posedge clk); @(negedge clk);
        miss_req = 1'b0; mem_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1; mem_rdata = beat_data(8'hA0, b);
            @(posedge clk); @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = beat_data(8'hA0, 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_v", cache_v, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (cache_load) saw = 1'b1;
        end
        mem_rvalid = 1'b0;
        chk("arst_no_load", saw, 0);
        chk("arst_busy_after", busy, 0);
        chk("arst_v_after", cache_v, 0);
        chk("arst_blk1", cache_block1[15:0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_fill.md
Name: icache_fill

Overview:
- Services instruction-cache misses raised by the fetch stage.
- On a miss request it fetches one 128-byte line from memory as eight 16-byte beats and writes it into the selected direct-mapped line (4 lines).
- It then updates that line's tag and valid bit and pulses cache_load so fetch retries.
- It owns the line storage, tags and valid bits that fetch reads combinationally.

Parameters:
- NUM_LINES, 4, number of direct-mapped lines (index = pc[8:7])
- LINE_BYTES, 128, bytes per line (offset = pc[6:0])
- BEAT_BYTES, 16, bytes per memory data beat
- TAG_W, 23, tag width (tag = pc[31:9])

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- miss_req  in  1  fetch miss request, level; sampled only in IDLE
- miss_pc  in  32  PC of the missing fetch, valid with miss_req
- inv_all  in  1  invalidate all lines (one-cycle pulse)
- mem_req  out  1  line read request, held until accepted
- mem_addr  out  32  line-aligned address, {miss_pc[31:7], 7'b0}
- mem_ready  in  1  memory accepts request when mem_req & mem_ready
- mem_rvalid  in  1  read data beat valid
- mem_rdata  in  128  beat data; byte i = mem_rdata[8*i +: 8] = address base+i
- cache_block0..3  out  [127:0][7:0]  line storage; element k = line byte k
- cache_tag  out  [3:0][22:0]  per-line tag
- cache_v  out  [3:0]  per-line valid
- cache_load  out  1  one-cycle pulse: fill complete
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state IDLE; mem_req=0, mem_addr=0, cache_load=0, busy=0, cache_v=0, all tags 0, all block bytes 0, beat counter 0.
- Reset mid-fill: the fill is abandoned and the line is left invalid; no cache_load is issued.
- FSM: IDLE -> REQ -> DATA -> DONE -> IDLE.
- IDLE:
  - On an edge with miss_req=1, latch idx=miss_pc[8:7], tag=miss_pc[31:9] and base={miss_pc[31:7],7'b0}.
  - On the same edge, clear cache_v[idx] and go to REQ.
- REQ: mem_req=1, mem_addr=base (both registered). On an edge with mem_ready=1, drop mem_req next cycle, set beat counter to 0 and go to DATA.
- DATA:
  - On each edge with mem_rvalid=1, write the 16 bytes to cache_block[idx][16*cnt + i], i=0..15, and increment the 3-bit counter.
  - On the edge accepting beat 7: cache_tag[idx]<=tag, cache_v[idx]<=1, go to DONE.
  - mem_rvalid gaps simply stall; there is no timeout.
- DONE: cache_load=1 for exactly this cycle; next edge -> IDLE. miss_req is ignored in DONE.
- Minimum latency: miss_req edge to cache_load high = 1 (REQ) + 1 (accept) + 8 beats = 10 cycles with mem_ready and mem_rvalid held high.
- mem_rvalid outside DATA is ignored, and storage is untouched.
- inv_all:
  - In any state, clears all cache_v bits on the next edge.
  - If it coincides with the final-beat edge, the fill's own valid set wins for idx; the other lines clear.
  - A fill in progress completes normally.
- Lines other than idx are never modified by a fill; their contents, tags and valid bits stay stable throughout.
- A miss to an already-valid matching line is refilled unconditionally; there is no hit check here.
- Storage writes are byte-exact. Fetch reads bytes big-endian from the line, so the byte order above is mandatory.

Decomposition:
- Shared package icache_pkg:
  - fill_state_t enum {IDLE, REQ, DATA, DONE}
  - constants NUM_LINES, LINE_BYTES, BEAT_BYTES, TAG_W, BEATS_PER_LINE=8
  - typedefs line_t = logic [127:0][7:0], tag_t = logic [22:0]
- One sub-module, icache_line_store: the 4 x 128-byte array with beat-write port (idx, beat, 128-bit data, we), exposing the four blocks.
- The FSM, tag and valid logic stay in icache_fill.

Test Plan:
- Basic fill:
  - Stimulus: reset; miss_req with miss_pc=0x0000_0180; mem_ready=1; 8 beats where beat b byte i = 16*b+i.
  - Required: mem_addr=0x0000_0180; cache_block3[k]=k for all k; cache_tag[3]=0; cache_v=4'b1000; cache_load exactly 1 cycle, 10 cycles after the request edge.
- Stalled memory:
  - Stimulus: mem_ready low 3 cycles; mem_rvalid toggled 1/0 across the 8 beats.
  - Required: mem_req held until accepted; data correct; cache_load only after beat 8.
- Invalidate during fill:
  - Stimulus: lines 0 and 1 pre-filled; fill line 2 with miss_pc=0x0001_0100; inv_all pulsed mid-DATA.
  - Required: cache_v[0] and cache_v[1]=0; cache_v[2]=1; cache_tag[2]=0x80.
- Refill same index:
  - Stimulus: fill miss_pc=0x0000_0000, then miss_pc=0x0000_0200.
  - Required: cache_v[0] low from the request edge until completion; cache_tag[0]=1 after completion; block0 holds the new data.
- Async reset mid-fill:
  - Stimulus: assert rst during beat 4, off a clock edge.
  - Required: immediate mem_req=0, cache_v=0, busy=0; no cache_load afterwards.
- Spurious input:
  - Stimulus: mem_rvalid with data 0xFF.. while IDLE.
  - Required: no storage change.
  - Stimulus: miss_req held through DONE.
  - Required: the new fill starts only from IDLE.
